// File: rtl/ysyx_23060025_rd_arbiter_if.sv
// ysyx_23060025_rd_arbiter_if: AXI4 read channel (AR + R) bundle shared by requesters and the downstream port
interface ysyx_23060025_rd_arbiter_if #(parameter int ADDR_LEN = 32, parameter int DATA_LEN = 32);
  logic arvalid, arready, rvalid, rlast, rready;
  logic [ADDR_LEN-1:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [DATA_LEN-1:0] rdata;
  modport master(output arvalid, araddr, arlen, arsize, rready, input arready, rdata, rvalid, rlast);
  modport slave(input arvalid, araddr, arlen, arsize, rready, output arready, rdata, rvalid, rlast);
endinterface

// File: rtl/ysyx_23060025_rd_arbiter.sv
// ysyx_23060025_rd_arbiter: IFU/LSU read arbiter, one burst in flight, burst-length check.
// ARB_RR_EN selects round-robin arbitration; otherwise the LSU has fixed priority.
module ysyx_23060025_rd_arbiter #(parameter int ADDR_LEN = 32, parameter int DATA_LEN = 32) (
  input  logic clock,
  input  logic reset,
  ysyx_23060025_rd_arbiter_if.slave  ifu,
  ysyx_23060025_rd_arbiter_if.slave  lsu,
  ysyx_23060025_rd_arbiter_if.master m,
  output logic busy,
  output logic len_err
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state, state_nxt;
  logic grant;
  logic [ADDR_LEN-1:0] req_addr;
  logic [7:0] req_len, beat_cnt;
  logic [2:0] req_size;
  logic req_any, sel_ls, lsu_first, ar_hs, r_hs, in_data;
`ifdef ARB_RR_EN
  logic last_grant;
  always_ff @(posedge clock)
    if (reset) last_grant <= 1'b0;
    else if (ar_hs) last_grant <= grant;
  assign lsu_first = ~last_grant;
`else
  assign lsu_first = 1'b1;
`endif
  assign req_any = ifu.arvalid | lsu.arvalid;
  assign sel_ls = lsu.arvalid & (~ifu.arvalid | lsu_first);
  assign ar_hs = (state == ADDR) & m.arready;
  assign in_data = state == DATA;
  assign r_hs = in_data & m.rvalid & m.rready;
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      grant <= 1'b0;
      beat_cnt <= 8'd0;
      len_err <= 1'b0;
      req_addr <= '0;
      req_len <= 8'd0;
      req_size <= 3'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_any) begin
        grant <= sel_ls;
        req_addr <= sel_ls ? lsu.araddr : ifu.araddr;
        req_len <= sel_ls ? lsu.arlen : ifu.arlen;
        req_size <= sel_ls ? lsu.arsize : ifu.arsize;
      end
      if (ar_hs) beat_cnt <= 8'd0;
      else if (r_hs) beat_cnt <= beat_cnt + 8'd1;
      // early rlast and a missing rlast on the final counted beat are both errors
      if (r_hs && (m.rlast ? beat_cnt != req_len : beat_cnt == req_len)) len_err <= 1'b1;
    end
  always_comb begin
    state_nxt = IDLE;
    if (state == IDLE) state_nxt = req_any ? ADDR : IDLE;
    else if (state == ADDR) state_nxt = m.arready ? DATA : ADDR;
    else if (state == DATA) state_nxt = (r_hs && m.rlast) ? IDLE : DATA;
  end
  always_comb begin
    busy = state != IDLE;
    m.arvalid = state == ADDR;
    m.araddr = req_addr;
    m.arlen = req_len;
    m.arsize = req_size;
    m.rready = in_data & (grant ? lsu.rready : ifu.rready);
    ifu.arready = ar_hs & ~grant;
    lsu.arready = ar_hs & grant;
    ifu.rdata = m.rdata;
    lsu.rdata = m.rdata;
    ifu.rvalid = in_data & ~grant & m.rvalid;
    lsu.rvalid = in_data & grant & m.rvalid;
    ifu.rlast = in_data & ~grant & m.rlast;
    lsu.rlast = in_data & grant & m.rlast;
  end
endmodule

// File: doc/ysyx_23060025_rd_arbiter.md
Name: ysyx_23060025_rd_arbiter

Overview:
- Arbitrates the single AXI4 read path (AR + R channels) between two requesters: instruction fetch (IFU, port prefix if_) and data load (LSU, port prefix ls_).
- Sits between the CPU-side request ports and the read side of the AXI controller/xbar.
- Owns exactly one outstanding read burst at a time.
- Routes returning R beats to the granted requester and checks burst length.

Parameters:
- ADDR_LEN, 32, address width.
- DATA_LEN, 32, read data width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- if_arvalid  in  1  IFU read request valid.
- if_araddr  in  ADDR_LEN  IFU burst start address.
- if_arlen  in  8  IFU burst length minus 1.
- if_arsize  in  3  IFU beat size.
- if_arready  out  1  IFU request accepted.
- if_rdata  out  DATA_LEN  IFU read data.
- if_rvalid  out  1  IFU beat valid.
- if_rlast  out  1  IFU last beat.
- if_rready  in  1  IFU can take a beat.
- ls_arvalid, ls_araddr, ls_arlen, ls_arsize, ls_arready, ls_rdata, ls_rvalid, ls_rlast, ls_rready: same directions, widths and meaning as the if_ ports, for the LSU.
- m_arvalid  out  1  downstream AR valid.
- m_araddr  out  ADDR_LEN  downstream AR address.
- m_arlen  out  8  downstream AR length.
- m_arsize  out  3  downstream AR size.
- m_arready  in  1  downstream AR ready.
- m_rdata  in  DATA_LEN  downstream read data.
- m_rvalid  in  1  downstream beat valid.
- m_rlast  in  1  downstream last beat.
- m_rready  out  1  downstream beat ready.
- busy  out  1  a transaction is in progress (state != IDLE).
- len_err  out  1  sticky flag: beat count did not match arlen.

Behaviour:
- FSM states: IDLE, ADDR, DATA. Reset returns to IDLE.
  - Reset values: grant=IFU, beat_cnt=0, len_err=0.
  - All valid and ready outputs are 0 in IDLE. Every m_* and requester-side valid/ready is derived from state, so reset forces them to 0.
- IDLE: if either arvalid is high, register the grant and the selected request's addr/len/size, then go to ADDR. The first m_arvalid appears one cycle after the request is seen.
  - Requesters hold arvalid and payload stable until their arready (AXI rule).
- Contention without ARB_RR_EN: the LSU wins (fixed priority).
- ADDR:
  - m_arvalid=1 and m_ar* come from the registered copy.
  - On m_arvalid & m_arready, pulse the granted requester's arready for that same cycle, clear beat_cnt, go to DATA.
  - The non-granted requester's arready stays 0.
- DATA:
  - m_rdata/m_rvalid/m_rlast are routed combinationally to the granted requester only; the other's rvalid=0.
  - m_rready = granted requester's rready.
  - Each m_rvalid & m_rready increments beat_cnt (8-bit, wraps at 255→0).
  - On a handshake with m_rlast=1, return to IDLE. The next arbitration happens in the following cycle (1 idle cycle minimum between bursts).
- Length check: on the last handshake, if beat_cnt != latched arlen, set len_err. len_err clears only on reset.
  - A beat with beat_cnt == arlen but m_rlast=0 also sets len_err; the FSM keeps waiting for rlast.
- A new arvalid arriving during ADDR or DATA is ignored until IDLE; its arready stays 0.
- Reset mid-burst: FSM returns to IDLE immediately and outstanding beats are dropped. The downstream slave is reset by the same global reset.
- No combinational path from m_arready to m_arvalid.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: round-robin. A 1-bit last_grant register (reset = IFU) updates on every AR handshake. On contention the requester that was NOT granted last wins, so the first contention after reset goes to the LSU. A single request is always granted.
- Undefined: fixed LSU priority; last_grant is not built.

Test Plan:
- Reset, then if_arvalid=1, addr=0x3000_0000, len=0. m_arvalid rises the next cycle with the same addr; m_arready=1 pulses if_arready. One beat with rdata=0xDEADBEEF and rlast=1 appears on if_rdata; ls_rvalid stays 0; busy returns to 0.
- if_ and ls_ arvalid asserted in the same cycle (ARB_RR_EN off):
  - LSU is granted first (addr 0x8000_0010).
  - IFU is granted after the LSU rlast, with at least 1 idle cycle.
  - Repeat 3 times: the LSU wins every time.
- Same as above with ARB_RR_EN defined, both held continuously: grants alternate LSU, IFU, LSU, IFU.
- IFU burst len=3 (4 beats) with ls_rready toggling and if_rready=0 for 2 cycles mid-burst: m_rready follows if_rready; all 4 beats are delivered in order; len_err=0.
- len=3 but the downstream asserts rlast on beat 2: len_err=1 and stays 1 across the next good burst until reset.
- reset asserted during the DATA state of a len=7 burst: the next cycle has busy=0, m_rready=0 and both rvalid=0. A new ls_arvalid after reset is granted normally.
